muldiv_issue_seq: RTL and testbench
===================================

# muldiv_issue_seq

Issue sequencer between the core execute stage and the M-extension MULDIV unit. It accepts one multiply/divide request over a valid/ready handshake and registers the operands, funct3 and destination tag. It holds the operands stable toward MULDIV, sends a one-cycle start pulse, then polls MULDIV busy. When busy drops it captures the result and presents it to writeback over a valid/ready handshake, together with a latency count.

## Interface
- DATA_WIDTH, 32, operand/result width (matches `DATA_WIDTH)
- TAG_WIDTH, 5, destination register tag width
- CNT_WIDTH, 6, latency counter width (saturating)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request valid from execute stage
- req_ready_o  out  1  request accepted when valid & ready
- req_rs1_i  in  DATA_WIDTH  multiplicand/dividend
- req_rs2_i  in  DATA_WIDTH  multiplier/divisor
- req_funct3_i  in  3  M-extension funct3
- req_rd_i  in  TAG_WIDTH  destination tag
- flush_i  in  1  pipeline kill; discards any in-flight request
- md_rs1_o  out  DATA_WIDTH  registered operand to MULDIV rs1_i
- md_rs2_o  out  DATA_WIDTH  registered operand to MULDIV rs2_i
- md_funct3_o  out  3  registered funct3 to MULDIV
- md_start_o  out  1  start pulse to MULDIV start_i
- md_c_i  in  DATA_WIDTH  MULDIV result, combinational
- md_busy_i  in  1  MULDIV busy (includes the start cycle)
- rsp_valid_o  out  1  result valid to writeback
- rsp_ready_i  in  1  writeback accepts
- rsp_data_o  out  DATA_WIDTH  captured result
- rsp_rd_o  out  TAG_WIDTH  captured tag
- rsp_cycles_o  out  CNT_WIDTH  cycles from ISSUE to capture, inclusive
- busy_o  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- req_ready_o = (state==IDLE) & !flush_i & !rst.
- **IDLE:**
  - On accept, latch rs1/rs2/funct3/rd into the operand registers.
  - Clear the counter to 1.
  - Go to ISSUE.
- **ISSUE:**
  - md_start_o=1 for exactly this cycle.
  - flush_i: go to DRAIN if md_busy_i, else IDLE.
  - Otherwise, if md_busy_i==0, capture md_c_i and the counter, then go to RESP. This covers MUL*, div-by-zero, signed overflow and repeated-operand remainder cases.
  - Otherwise go to WAIT.
- **WAIT:**
  - md_start_o=0 and the counter increments, saturating at all-ones.
  - flush_i: go to DRAIN if md_busy_i, else IDLE.
  - Otherwise, if md_busy_i==0, capture md_c_i and the counter, then go to RESP.
- **RESP:**
  - rsp_valid_o=1; rsp_data_o, rsp_rd_o and rsp_cycles_o are held stable.
  - rsp_ready_i: go to IDLE.
  - flush_i: drop the response and go to IDLE. Flush has priority over rsp_ready_i.
- **DRAIN:**
  - No response is produced. Wait for md_busy_i==0, then go to IDLE.
  - flush_i is ignored.
- Operand registers (md_rs1_o, md_rs2_o, md_funct3_o) change only on accept. They are never cleared between operations, so MULDIV's same-operand remainder shortcut remains effective.
- md_c_i is sampled only on the capture edge; it is never registered earlier.

## Timing
- Reset values:
  - state=IDLE
  - md_start_o=0, rsp_valid_o=0, busy_o=0
  - all data, tag and counter registers = 0
  - req_ready_o=0 while rst is high
- Single-cycle MULDIV op: accept at edge N, ISSUE in cycle N+1, rsp_valid_o in cycle N+2, rsp_cycles_o=1.
- Multi-cycle op: rsp_valid_o is asserted the cycle after the first cycle in which md_busy_i==0. rsp_cycles_o equals the number of cycles spent in ISSUE+WAIT.
- Minimum occupancy is 3 cycles per operation (IDLE, ISSUE, RESP); there is no overlap.
- md_start_o is never high for two consecutive cycles, and never high outside ISSUE.
- rst mid-operation:
  - Returns to IDLE next edge; no response is produced.
  - MULDIV must be reset by the same system reset; the sequencer does not drain.

## Test plan
- MUL: rs1=7, rs2=0xFFFFFFFD, funct3=000 -> rsp_data=0xFFFFFFEB, rsp_cycles=1, rsp_valid 2 cycles after accept, md_start exactly 1 cycle.
- DIVU 100/7 then REMU 100/7, rd=3 then rd=4 -> rsp_data=14 with rsp_cycles = divider latency, then rsp_data=2 with rsp_cycles=1 and a single start pulse. Verifies the operand registers were not disturbed.
- DIV 5/0 -> 0xFFFFFFFF, rsp_cycles=1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, rsp_cycles=1.
- DIVU 1000/3 with flush_i pulsed in the 3rd WAIT cycle:
  - no rsp_valid
  - busy_o stays high until md_busy_i falls, then one cycle later req_ready_o=1
  - next request MULHU 0xFFFFFFFF*2 -> 0x00000001
- rsp_ready_i held low for 5 cycles during RESP:
  - rsp_valid/data/rd stable
  - req_ready_o=0 throughout
  - accept on the 6th cycle, then IDLE
- rst asserted in WAIT:
  - next cycle all outputs at reset values, no rsp_valid
  - after release, REM 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFF

Source files
------------

// File: rtl/muldiv_issue_seq.sv
// Issue sequencer for the M-extension MULDIV unit: registers one request, pulses start,
// polls busy, captures the result and hands it to writeback with a latency count.
module muldiv_issue_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_rs1_i,
    input  logic [DATA_WIDTH-1:0] req_rs2_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [TAG_WIDTH-1:0]  req_rd_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] md_rs1_o,
    output logic [DATA_WIDTH-1:0] md_rs2_o,
    output logic [2:0]            md_funct3_o,
    output logic                  md_start_o,
    input  logic [DATA_WIDTH-1:0] md_c_i,
    input  logic                  md_busy_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [TAG_WIDTH-1:0]  rsp_rd_o,
    output logic [CNT_WIDTH-1:0]  rsp_cycles_o,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [DATA_WIDTH-1:0] r_rs1;
    logic [DATA_WIDTH-1:0] r_rs2;
    logic [2:0]            r_funct3;
    logic [TAG_WIDTH-1:0]  r_rd;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [TAG_WIDTH-1:0]  r_rsp_rd;
    logic [CNT_WIDTH-1:0]  r_rsp_cycles;

    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_polling;
    logic                  w_capture;
    logic                  w_cnt_inc;

    assign w_req_ready = (r_state == ST_IDLE) & ~flush_i & ~rst;
    assign w_accept    = req_valid_i & w_req_ready;
    assign w_polling   = (r_state == ST_ISSUE) | (r_state == ST_WAIT);
    assign w_capture   = w_polling & ~flush_i & ~md_busy_i;
    // The count always reflects cycles spent so far including the current one,
    // so it advances on every edge that lands in WAIT.
    assign w_cnt_inc   = (w_state_next == ST_WAIT) & ~(&r_cnt);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (flush_i) begin
                    w_state_next = md_busy_i ? ST_DRAIN : ST_IDLE;
                end else if (!md_busy_i) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (flush_i || rsp_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!md_busy_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operands persist across operations so MULDIV can spot a repeated-operand remainder.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_funct3 <= '0;
            r_rd     <= '0;
        end else if (w_accept) begin
            r_rs1    <= req_rs1_i;
            r_rs2    <= req_rs2_i;
            r_funct3 <= req_funct3_i;
            r_rd     <= req_rd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_WIDTH'(1);
        end else if (w_polling && w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data   <= '0;
            r_rsp_rd     <= '0;
            r_rsp_cycles <= '0;
        end else if (w_capture) begin
            r_rsp_data   <= md_c_i;
            r_rsp_rd     <= r_rd;
            r_rsp_cycles <= r_cnt;
        end
    end

    assign req_ready_o  = w_req_ready;
    assign md_rs1_o     = r_rs1;
    assign md_rs2_o     = r_rs2;
    assign md_funct3_o  = r_funct3;
    assign md_start_o   = (r_state == ST_ISSUE);
    assign rsp_valid_o  = (r_state == ST_RESP);
    assign rsp_data_o   = r_rsp_data;
    assign rsp_rd_o     = r_rsp_rd;
    assign rsp_cycles_o = r_rsp_cycles;
    assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_issue_seq.sv
// Bench for muldiv_issue_seq: a behavioural MULDIV stand-in plus directed and
// randomized transactions checked against arithmetic reference results.
module tb_muldiv_issue_seq;

    localparam logic [31:0] MIN_INT = 32'h8000_0000;
    localparam logic [31:0] ALL_ONE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        flush;
    logic [31:0] md_rs1;
    logic [31:0] md_rs2;
    logic [2:0]  md_funct3;
    logic        md_start;
    logic [31:0] md_c;
    logic        md_busy;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [5:0]  rsp_cycles;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // MULDIV stand-in state
    int          div_busy = 8;
    int          remaining;
    logic        ld_valid;
    logic [31:0] ld_a;
    logic [31:0] ld_b;
    logic        ld_signed;

    muldiv_issue_seq dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_rs1_i    (req_rs1),
        .req_rs2_i    (req_rs2),
        .req_funct3_i (req_funct3),
        .req_rd_i     (req_rd),
        .flush_i      (flush),
        .md_rs1_o     (md_rs1),
        .md_rs2_o     (md_rs2),
        .md_funct3_o  (md_funct3),
        .md_start_o   (md_start),
        .md_c_i       (md_c),
        .md_busy_i    (md_busy),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_rd_o     (rsp_rd),
        .rsp_cycles_o (rsp_cycles),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        logic [63:0] pu;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return ALL_ONE;
                if (a == MIN_INT && b == ALL_ONE) return MIN_INT;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return ALL_ONE;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == ALL_ONE) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Multi-cycle only for a real divide: not by zero, not signed overflow,
    // not a remainder that repeats the operands of the previous divide.
    function automatic bit needs_multi(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                       input logic lv, input logic [31:0] la, input logic [31:0] lb,
                                       input logic ls);
        if (!f3[2]) return 1'b0;
        if (b == 0) return 1'b0;
        if (!f3[0] && a == MIN_INT && b == ALL_ONE) return 1'b0;
        if (f3[1] && lv && la == a && lb == b && ls == !f3[0]) return 1'b0;
        return 1'b1;
    endfunction

    assign md_c = ref_result(md_funct3, md_rs1, md_rs2);

    always_comb begin
        md_busy = (remaining != 0);
        if (md_start && needs_multi(md_funct3, md_rs1, md_rs2, ld_valid, ld_a, ld_b, ld_signed))
            md_busy = 1'b1;
    end

    always @(posedge clk) begin
        if (rst) begin
            remaining <= 0;
            ld_valid  <= 1'b0;
        end else begin
            if (md_start && md_busy) remaining <= div_busy - 1;
            else if (remaining > 0)  remaining <= remaining - 1;
            if (md_start && md_funct3[2] && !md_funct3[1]) begin
                ld_valid  <= 1'b1;
                ld_a      <= md_rs1;
                ld_b      <= md_rs2;
                ld_signed <= !md_funct3[0];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Presents one request and returns at the first negedge with rsp_valid high.
    task automatic issue_wait(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, output int starts, output int lat, output bit tmo);
        int n;
        tmo = 1'b0; starts = 0; lat = 0; n = 0;
        req_valid = 1'b1; req_rs1 = a; req_rs2 = b; req_funct3 = f3; req_rd = rd;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin req_valid = 1'b0; tmo = 1'b1; return; end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 300) begin
            if (md_start) starts++;
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) tmo = 1'b1;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (md_start !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got start=%b valid=%b expected 0 0", md_start, rsp_valid); end
        n_checks++; if ({md_rs1, md_rs2, md_funct3} !== 67'd0) begin n_fail++; $display("FAIL reset_operands: got %h %h %h expected zeros", md_rs1, md_rs2, md_funct3); end
        n_checks++; if ({rsp_data, rsp_rd, rsp_cycles} !== 43'd0) begin n_fail++; $display("FAIL reset_rsp: got %h %h %h expected zeros", rsp_data, rsp_rd, rsp_cycles); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_mul();
        int st, lat; bit tmo;
        issue_wait(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd1, st, lat, tmo);
        $display("txn mul 7*-3 data=%h cycles=%0d lat=%0d", rsp_data, rsp_cycles, lat);
        n_checks++; if (tmo) begin n_fail++; $display("FAIL mul_timeout: got timeout expected response"); end
        n_checks++; if (rsp_data !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_data: got %h expected ffffffeb", rsp_data); end
        n_checks++; if (rsp_cycles !== 6'd1) begin n_fail++; $display("FAIL mul_cycles: got %0d expected 1", rsp_cycles); end
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL mul_latency: got %0d expected 2", lat); end
        n_checks++; if (st !== 1) begin n_fail++; $display("FAIL mul_starts: got %0d expected 1", st); end
        n_checks++; if (rsp_rd !== 5'd1) begin n_fail++; $display("FAIL mul_rd: got %0d expected 1", rsp_rd); end
        release_rsp();
    endtask

    task automatic test_div_rem();
        int st, lat; bit tmo;
        div_busy = 8;
        issue_wait(3'b101, 32'd100, 32'd7, 5'd3, st, lat, tmo);
        $display("txn divu 100/7 data=%0d cycles=%0d", rsp_data, rsp_cycles);
        n_checks++; if (tmo || rsp_data !== 32'd14) begin n_fail++; $display("FAIL divu_data: got %0d expected 14", rsp_data); end
        n_checks++; if (rsp_cycles !== 6'd9) begin n_fail++; $display("FAIL divu_cycles: got %0d expected 9", rsp_cycles); end
        n_checks++; if (rsp_rd !== 5'd3 || st !== 1) begin n_fail++; $display("FAIL divu_rd_starts: got rd=%0d starts=%0d expected 3 1", rsp_rd, st); end
        release_rsp();
        issue_wait(3'b111, 32'd100, 32'd7, 5'd4, st, lat, tmo);
        $display("txn remu 100/7 data=%0d cycles=%0d", rsp_data, rsp_cycles);
        n_checks++; if (tmo || rsp_data !== 32'd2) begin n_fail++; $display("FAIL remu_data: got %0d expected 2", rsp_data); end
        n_checks++; if (rsp_cycles !== 6'd1 || st !== 1) begin n_fail++; $display("FAIL remu_cycles: got cycles=%0d starts=%0d expected 1 1", rsp_cycles, st); end
        n_checks++; if (rsp_rd !== 5'd4) begin n_fail++; $display("FAIL remu_rd: got %0d expected 4", rsp_rd); end
        release_rsp();
    endtask

    task automatic test_div_special();
        int st, lat; bit tmo;
        issue_wait(3'b100, 32'd5, 32'd0, 5'd5, st, lat, tmo);
        $display("txn div 5/0 data=%h cycles=%0d", rsp_data, rsp_cycles);
        n_checks++; if (tmo || rsp_data !== ALL_ONE || rsp_cycles !== 6'd1) begin n_fail++; $display("FAIL div_by_zero: got %h/%0d expected ffffffff/1", rsp_data, rsp_cycles); end
        release_rsp();
        issue_wait(3'b100, MIN_INT, ALL_ONE, 5'd6, st, lat, tmo);
        $display("txn div min/-1 data=%h cycles=%0d", rsp_data, rsp_cycles);
        n_checks++; if (tmo || rsp_data !== MIN_INT || rsp_cycles !== 6'd1) begin n_fail++; $display("FAIL div_overflow: got %h/%0d expected 80000000/1", rsp_data, rsp_cycles); end
        release_rsp();
    endtask

    task automatic test_flush();
        int n, st, lat; bit tmo, seen_valid, busy_drop;
        div_busy = 10;
        n = 0; seen_valid = 1'b0; busy_drop = 1'b0;
        req_valid = 1'b1; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_funct3 = 3'b101; req_rd = 5'd7;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n = 0;
        while (md_busy && n < 100) begin
            if (rsp_valid) seen_valid = 1'b1;
            if (!busy) busy_drop = 1'b1;
            @(negedge clk);
            n++;
        end
        $display("txn divu 1000/3 flushed, drain cycles=%0d", n);
        n_checks++; if (n >= 100) begin n_fail++; $display("FAIL flush_timeout: got md_busy stuck expected release"); end
        n_checks++; if (seen_valid || rsp_valid) begin n_fail++; $display("FAIL flush_no_rsp: got rsp_valid expected none"); end
        n_checks++; if (busy_drop || busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_drain_busy: got busy=%b drop=%b ready=%b expected 1 0 0", busy, busy_drop, req_ready); end
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got ready=%b busy=%b expected 1 0", req_ready, busy); end
        issue_wait(3'b011, ALL_ONE, 32'd2, 5'd8, st, lat, tmo);
        $display("txn mulhu ffffffff*2 data=%h cycles=%0d", rsp_data, rsp_cycles);
        n_checks++; if (tmo || rsp_data !== 32'd1 || rsp_cycles !== 6'd1) begin n_fail++; $display("FAIL flush_next_mulhu: got %h/%0d expected 1/1", rsp_data, rsp_cycles); end
        release_rsp();
    endtask

    task automatic test_backpressure();
        int st, lat; bit tmo;
        issue_wait(3'b000, 32'h0000_1234, 32'h10, 5'd9, st, lat, tmo);
        $display("txn mul 1234*10 held 5 cycles");
        n_checks++; if (tmo) begin n_fail++; $display("FAIL bp_timeout: got timeout expected response"); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0001_2340 || rsp_rd !== 5'd9 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b d=%h rd=%0d rdy=%b expected 1 00012340 9 0", i, rsp_valid, rsp_data, rsp_rd, req_ready);
            end
            @(negedge clk);
        end
        release_rsp();
        n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got busy=%b valid=%b ready=%b expected 0 0 1", busy, rsp_valid, req_ready); end
    endtask

    task automatic test_rst_mid();
        int n, st, lat; bit tmo;
        div_busy = 10;
        n = 0;
        req_valid = 1'b1; req_rs1 = 32'd1000; req_rs2 = 32'd3; req_funct3 = 3'b100; req_rd = 5'd10;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || md_start !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got v=%b b=%b s=%b r=%b expected 0 0 0 0", rsp_valid, busy, md_start, req_ready); end
        n_checks++; if ({md_rs1, md_rs2, md_funct3} !== 67'd0) begin n_fail++; $display("FAIL rstmid_operands: got %h %h %h expected zeros", md_rs1, md_rs2, md_funct3); end
        n_checks++; if ({rsp_data, rsp_rd, rsp_cycles} !== 43'd0) begin n_fail++; $display("FAIL rstmid_rsp: got %h %h %h expected zeros", rsp_data, rsp_rd, rsp_cycles); end
        rst = 1'b0;
        @(negedge clk);
        issue_wait(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, st, lat, tmo);
        $display("txn rem -7/2 data=%h cycles=%0d", rsp_data, rsp_cycles);
        n_checks++; if (tmo || rsp_data !== ALL_ONE) begin n_fail++; $display("FAIL rstmid_rem: got %h expected ffffffff", rsp_data); end
        n_checks++; if (rsp_cycles !== 6'd11) begin n_fail++; $display("FAIL rstmid_rem_cycles: got %0d expected 11", rsp_cycles); end
        release_rsp();
    endtask

    task automatic test_random();
        logic [2:0]  f3, pf3;
        logic [31:0] a, b, pa, pb, exp_d;
        logic [4:0]  rd;
        int          st, lat, exp_c, exp_lat, hold;
        bit          tmo, m;
        pf3 = 3'b000; pa = 0; pb = 0;
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = MIN_INT; b = ALL_ONE; end
                2: b = 32'($urandom_range(1, 5));
                default: ;
            endcase
            if (pf3[2] && !pf3[1] && $urandom_range(0, 2) == 0) begin
                a = pa; b = pb; f3 = pf3 | 3'b010;
            end
            rd       = 5'($urandom);
            hold     = $urandom_range(0, 3);
            div_busy = $urandom_range(1, 70);
            exp_d    = ref_result(f3, a, b);
            m        = needs_multi(f3, a, b, ld_valid, ld_a, ld_b, ld_signed);
            exp_c    = m ? ((div_busy + 1 > 63) ? 63 : div_busy + 1) : 1;
            exp_lat  = m ? div_busy + 2 : 2;
            issue_wait(f3, a, b, rd, st, lat, tmo);
            $display("txn rnd%0d f3=%0d a=%h b=%h data=%h cycles=%0d", i, f3, a, b, rsp_data, rsp_cycles);
            n_checks++;
            if (tmo || rsp_data !== exp_d || rsp_rd !== rd) begin
                n_fail++;
                $display("FAIL rnd%0d_data: got %h rd=%0d expected %h rd=%0d", i, rsp_data, rsp_rd, exp_d, rd);
            end
            n_checks++;
            if (rsp_cycles !== 6'(exp_c) || lat !== exp_lat || st !== 1) begin
                n_fail++;
                $display("FAIL rnd%0d_timing: got cyc=%0d lat=%0d st=%0d expected %0d %0d 1", i, rsp_cycles, lat, st, exp_c, exp_lat);
            end
            repeat (hold) @(negedge clk);
            release_rsp();
            pf3 = f3; pa = a; pb = b;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_funct3 = '0;
        req_rd = '0; flush = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_mul();
        test_div_rem();
        test_div_special();
        test_flush();
        test_backpressure();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
